// File: rtl/ram_reader.sv
`default_nettype none
// ============================================================================
// Module   : ram_reader
// Brief    : Raster read-back engine for the 160x120 3-bit game RAM. Walks
//            every cell in raster order (x fastest), issues one synchronous
//            read per non-held cycle and emits a registered plot stream
//            (x, y, colour, plot) for the VGA adapter.
// Revision : 1.0 - initial release
// ============================================================================
module ram_reader #(
  parameter int WIDTH   = 160,
  parameter int HEIGHT  = 120,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 3
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic               hold,
  output logic [X_W+Y_W-1:0] address,
  input  logic [COLOR_W-1:0] q,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COLOR_W-1:0] colour,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  // Last coordinates of the frame; counters never exceed these.
  localparam logic [X_W-1:0] c_X_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] c_Y_LAST = Y_W'(HEIGHT - 1);

  // Scan state encoding.
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_SCAN  = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;

  // Scan counters (coordinate of the next read to issue).
  logic [X_W-1:0]     r_sx;
  logic [Y_W-1:0]     r_sy;

  // Stage 1: registered read address plus coordinate copies.
  logic               r_v1;
  logic [X_W+Y_W-1:0] r_address;
  logic [X_W-1:0]     r_x1;
  logic [Y_W-1:0]     r_y1;

  // Stage 2: registered plot outputs.
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic [COLOR_W-1:0] r_colour;
  logic               r_plot;
  logic               r_done;

  // Decoded controls.
  logic               w_accept;
  logic               w_issue;
  logic               w_last_issue;
  logic               w_busy;
  logic               w_x_wrap;
  logic               w_last_pixel;

  assign w_x_wrap     = (r_sx == c_X_LAST);
  assign w_last_issue = w_x_wrap && (r_sy == c_Y_LAST);
  assign w_last_pixel = r_v1 && (r_x1 == c_X_LAST) && (r_y1 == c_Y_LAST);

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: drain waits for the last read to leave stage 1.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (start) begin
          w_next_state = c_ST_SCAN;
        end
      end
      c_ST_SCAN: begin
        if (!hold && w_last_issue) begin
          w_next_state = c_ST_DRAIN;
        end
      end
      c_ST_DRAIN: begin
        if (!r_v1) begin
          w_next_state = c_ST_IDLE;
        end
      end
      default: begin
        w_next_state = c_ST_IDLE;
      end
    endcase
  end

  // Output decode: start acceptance, read issue and busy flag.
  always_comb begin
    w_accept = 1'b0;
    w_issue  = 1'b0;
    w_busy   = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        w_accept = start;
      end
      c_ST_SCAN: begin
        w_issue = !hold;
        w_busy  = 1'b1;
      end
      c_ST_DRAIN: begin
        w_busy = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Raster counters: zeroed on accept, advanced only on issue cycles.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_sx <= '0;
      r_sy <= '0;
    end else if (w_accept) begin
      r_sx <= '0;
      r_sy <= '0;
    end else if (w_issue) begin
      if (w_x_wrap) begin
        r_sx <= '0;
        r_sy <= r_sy + 1'b1;
      end else begin
        r_sx <= r_sx + 1'b1;
      end
    end
  end

  // Stage 1: present the read address; a held cycle injects a bubble.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_v1      <= 1'b0;
      r_address <= '0;
      r_x1      <= '0;
      r_y1      <= '0;
    end else begin
      r_v1 <= w_issue;
      if (w_issue) begin
        r_address <= {r_sx, r_sy};
        r_x1      <= r_sx;
        r_y1      <= r_sy;
      end
    end
  end

  // Stage 2: capture RAM data with its coordinates; never stalled by hold.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_plot <= r_v1;
      r_done <= w_last_pixel;
      if (r_v1) begin
        r_x      <= r_x1;
        r_y      <= r_y1;
        r_colour <= q;
      end
    end
  end

  assign address = r_address;
  assign x       = r_x;
  assign y       = r_y;
  assign colour  = r_colour;
  assign plot    = r_plot;
  assign busy    = w_busy;
  assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_reader
// Brief    : Self-checking bench for ram_reader. A reference model derives the
//            expected plot stream (pixel index, plot cycle) from the scan
//            rules; a RAM model returns (x+y)%8, or a wrong colour after a
//            held cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_reader;

  localparam int c_W    = 160;
  localparam int c_H    = 120;
  localparam int c_NPIX = c_W * c_H;

  logic        CLOCK_50;
  logic        reset;
  logic        start;
  logic        hold;
  logic [14:0] address;
  logic [2:0]  q;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  ram_reader #(
    .WIDTH(c_W), .HEIGHT(c_H), .X_W(8), .Y_W(7), .COLOR_W(3)
  ) u_dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .hold(hold),
    .address(address), .q(q), .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy), .done(done)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_assert++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp_v, $time);
    end
  endtask

  function automatic int col_of(input logic [14:0] a);
    return (int'(a[14:7]) + int'(a[6:0])) % 8;
  endfunction

  // RAM model: colour = (x+y)%8, deliberately wrong data after a held cycle.
  logic       r_hold_s = 1'b0;
  logic [2:0] r_garb   = 3'd0;
  always @(posedge CLOCK_50) begin
    r_hold_s <= hold;
    r_garb   <= 3'((col_of(address) + 1 + int'($urandom_range(0, 6))) % 8);
  end
  assign q = r_hold_s ? r_garb : 3'(col_of(address));

  // Reference model: each unheld scan edge emits the next pixel index, which
  // must appear on the plot outputs in the period after the following edge.
  typedef struct {int t; int k;} pix_t;
  pix_t exp_q[$];
  int   edge_n        = 0;
  bit   m_scan        = 1'b0;
  int   m_n           = 0;
  bit   exp_busy_prev = 1'b0;

  always @(posedge CLOCK_50) begin
    edge_n++;
    if (!reset) begin
      if (m_scan) begin
        if (!hold) begin
          exp_q.push_back('{edge_n + 1, m_n});
          m_n++;
          if (m_n == c_NPIX) m_scan = 1'b0;
        end
      end else if (start && !exp_busy_prev) begin
        m_scan = 1'b1;
        m_n    = 0;
      end
    end
  end

  // Monitor: compare outputs against the model mid-cycle.
  logic [14:0] prev_addr = '0;
  logic [14:0] wrap_a = '0, wrap_b = '0, last_a = '0;
  int   first_plot = -1, done_e = -1, busy_fall = -1, done_cnt = 0;
  bit   prev_busy = 1'b0, mon_ep, mon_eb;
  pix_t mon_p;
  int   mon_xe, mon_ye;

  always @(negedge CLOCK_50) begin
    if (reset) begin
      exp_busy_prev = 1'b0;
      prev_busy     = 1'b0;
    end else begin
      mon_ep = (exp_q.size() > 0) && (exp_q[0].t == edge_n);
      mon_eb = m_scan || (exp_q.size() > 0);
      check("plot", 32'(plot), 32'(mon_ep));
      check("busy", 32'(busy), 32'(mon_eb));
      if (mon_ep) begin
        mon_p  = exp_q.pop_front();
        mon_xe = mon_p.k % c_W;
        mon_ye = mon_p.k / c_W;
        check("x", 32'(x), 32'(mon_xe));
        check("y", 32'(y), 32'(mon_ye));
        check("colour", 32'(colour), 32'((mon_xe + mon_ye) % 8));
        check("done", 32'(done), 32'(mon_p.k == c_NPIX - 1));
        check("addr", 32'(prev_addr), 32'({mon_xe[7:0], mon_ye[6:0]}));
        if (mon_p.k == c_W - 1)    wrap_a = prev_addr;
        if (mon_p.k == c_W)        wrap_b = prev_addr;
        if (mon_p.k == c_NPIX - 1) last_a = prev_addr;
      end else begin
        check("done_idle", 32'(done), 32'd0);
      end
      if (plot && x == 8'd0 && y == 7'd0) first_plot = edge_n;
      if (done) begin
        done_cnt++;
        done_e = edge_n;
      end
      if (prev_busy && !busy) busy_fall = edge_n;
      prev_busy     = busy;
      exp_busy_prev = mon_eb;
    end
    prev_addr = address;
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic goto_edge(input int target);
    while (edge_n < target) step();
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_address"}, 32'(address), 32'd0);
    check({pfx, "_x"},       32'(x),       32'd0);
    check({pfx, "_y"},       32'(y),       32'd0);
    check({pfx, "_colour"},  32'(colour),  32'd0);
    check({pfx, "_plot"},    32'(plot),    32'd0);
    check({pfx, "_busy"},    32'(busy),    32'd0);
    check({pfx, "_done"},    32'(done),    32'd0);
  endtask

  int e0, e1, e2, e3, dc;

  initial begin
    start = 1'b0;
    hold  = 1'b0;
    reset = 1'b1;
    #2;
    check_zero("rst");
    repeat (3) step();
    reset = 1'b0;
    step();
    check_zero("idle");

    // Frame 1: unstalled, with starts at cycles 500 and 19202 to be ignored.
    e0 = edge_n + 1;
    start = 1'b1; step(); start = 1'b0;
    goto_edge(e0 + 499);   start = 1'b1; step(); start = 1'b0;
    goto_edge(e0 + 19201); start = 1'b1; step(); start = 1'b0;
    // Start sampled at cycle 19204 opens frame 2.
    goto_edge(e0 + 19203); start = 1'b1; step(); start = 1'b0;
    e1 = e0 + 19204;
    check("f1_first_plot_cyc", 32'(first_plot - e0 + 1), 32'd3);
    check("f1_done_cyc",       32'(done_e - e0 + 1),     32'd19202);
    check("f1_busy_fall_cyc",  32'(busy_fall - e0 + 1),  32'd19203);
    check("f1_done_cnt",       32'(done_cnt),            32'd1);
    check("wrap_addr_a",       32'(wrap_a),              32'h4F80);
    check("wrap_addr_b",       32'(wrap_b),              32'h0001);
    check("last_addr",         32'(last_a),              32'h4FF7);

    // Frame 2: three held cycles after issue 1000 (x=40, y=6).
    goto_edge(e1 + 3);
    check("f2_first_plot_cyc", 32'(first_plot - e0 + 1), 32'd19207);
    goto_edge(e1 + 1001); hold = 1'b1;
    goto_edge(e1 + 1004); hold = 1'b0;
    goto_edge(e1 + 19206);
    check("f2_done_cyc", 32'(done_e - e1 + 1), 32'd19205);
    check("f2_done_cnt", 32'(done_cnt),        32'd2);

    // Frame 3: random holds and stray starts, aborted by reset at cycle 5000.
    e2 = edge_n + 1;
    start = 1'b1; step(); start = 1'b0;
    while (edge_n < e2 + 4999) begin
      hold  = ($urandom_range(0, 7) == 0);
      start = ($urandom_range(0, 63) == 0);
      step();
    end
    hold  = 1'b0;
    start = 1'b0;
    dc    = done_cnt;
    #2;
    reset = 1'b1;
    exp_q.delete();
    m_scan = 1'b0;
    #1;
    check_zero("arst");
    goto_edge(e2 + 5001);
    reset = 1'b0;
    repeat (3) step();
    check_zero("post_rst");
    check("abort_done_cnt", 32'(done_cnt), 32'(dc));

    // Frame 4: restart scans from address 0, then random holds.
    e3 = edge_n + 1;
    start = 1'b1; step(); start = 1'b0;
    step();
    check("restart_addr", 32'(address), 32'd0);
    while (edge_n < e3 + 3000) begin
      hold  = ($urandom_range(0, 5) == 0);
      start = ($urandom_range(0, 99) == 0);
      step();
    end
    hold  = 1'b0;
    start = 1'b0;
    check("f4_no_done", 32'(done_cnt), 32'(dc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_reader.md
# ram_reader

Raster read-back engine for the 160x120, 3-bit-colour game RAM. On a start request it walks every cell in raster order and issues one synchronous read per cycle on a shared read port. It returns each cell's colour with its coordinates as a plot stream for the VGA adapter. It is the consumer end of the playfield RAM that the game logic writes trails into. Reads yield to an external hold (arbiter grant to the writer) without losing or duplicating pixels.

## Interface
- WIDTH, 160, columns per frame (x range 0..WIDTH-1)
- HEIGHT, 120, rows per frame (y range 0..HEIGHT-1)
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COLOR_W, 3, colour width
- CLOCK_50  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  one-cycle frame-scan request; accepted only in IDLE
- hold  in  1  when high, no read is issued this cycle (RAM port belongs to writer)
- address  out  15  RAM read address = {x[7:0], y[6:0]}
- q  in  3  RAM read data, valid one cycle after address is presented
- x  out  8  pixel x, registered
- y  out  7  pixel y, registered
- colour  out  3  pixel colour, registered
- plot  out  1  x/y/colour valid this cycle
- busy  out  1  high from first scan cycle through final plot
- done  out  1  one-cycle pulse, coincident with final plot

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE: busy=0. If start=1, move to SCAN and zero the scan counters (sx=0, sy=0).
- SCAN: each cycle with hold=0 is an issue cycle:
  - address <= {sx, sy}, registered, so the RAM sees it in the following cycle.
  - Advance the counters: sx+1. When sx==WIDTH-1, sx wraps to 0 and sy increments.
  - After the issue of (WIDTH-1, HEIGHT-1), move to DRAIN.
- With hold=1 in SCAN: the counters and address hold, and no valid bit enters the pipeline.
- Pipeline: valid bit v1 (address registered) -> v2 (q sampled).
  - Stage-1 coordinate copies travel with v1.
  - When v1 is set, the stage-2 registers load x, y and colour<=q, and plot<=1.
  - In-flight reads are never stalled by hold.
- DRAIN: wait until the pipeline is empty, then return to IDLE.
  - done=1 in the cycle the last plot (x=159, y=119) is asserted.
  - busy falls in the following cycle.
- start outside IDLE is ignored, including in the cycle done is high.
- Counter arithmetic: compare against WIDTH-1 and HEIGHT-1 only. Values ≥WIDTH or ≥HEIGHT are never generated.
- Reset (any time, including mid-scan):
  - State goes to IDLE; sx, sy, address, x, y, colour all go to 0.
  - plot, busy, done and valid bits go to 0.
  - No done is produced for the aborted frame.

## Timing
- Reset values: address=0, x=0, y=0, colour=0, plot=0, busy=0, done=0.
- start sampled high at edge 0:
  - SCAN from cycle 1.
  - Issue k (k=0..19199) in cycle 1+k when hold is never asserted.
  - Address for issue k is visible in cycle 2+k.
  - The matching plot appears in cycle 3+k.
- Unstalled frame:
  - First plot (0,0) in cycle 3; last plot and done in cycle 19202.
  - busy is high in cycles 1..19202.
- Each hold cycle during SCAN delays all later plots and done by exactly one cycle.
- Throughput: one pixel per non-held cycle. Exactly 19200 plots per completed frame, each coordinate once, in raster order (x fastest).
- Last address: {8'd159, 7'd119} = 15'h4FF7.

## Test plan
- Reset check: assert reset mid-cycle, asynchronously. All outputs are 0 immediately, before the next edge; state is IDLE.
- Full frame: RAM model colour=(x+y)%8, start pulse at cycle 0, hold=0.
  - Expect 19200 plots in raster order with matching colours.
  - First plot (0,0,c=0) at cycle 3; done with (159,119,c=6) at cycle 19202.
  - busy falls at cycle 19203.
- Hold: assert hold for 3 cycles after issue 1000 (x=40, y=6).
  - No missing or duplicate coordinates.
  - Colours stay correct even though the RAM model returns garbage on held cycles.
  - done arrives at cycle 19205.
- Start while busy: pulse start at cycles 500 and 19202.
  - Both are ignored; exactly one done.
  - A start at cycle 19204 begins a new frame with a plot (0,0) at cycle 19207.
- Reset mid-scan: assert reset at cycle 5000, release at 5002.
  - No done; all outputs are 0.
  - A subsequent start rescans from address 0.
- Row wrap: check the issue after (159,0) is (0,1), with address 15'h4F80 followed by 15'h0001.
